// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder built from 2:1 multiplexers around the propagate term.
module full_adder_mux (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = ci ? ~p : p;
   // When a and b differ the carry is passed through, otherwise it equals a (= b).
   assign co = p ? ci : a;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell per clock, start/busy/done handshake.
// Optional subtract mode and overflow flag are built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_SUB_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_co;

   full_adder_mux u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
               // a - b computed as a + ~b + 1; cin plays no part here.
               if (sub) begin
                  b_sh_d  = ~b;
                  carry_d = 1'b1;
               end
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            // Result registers change only here, so partial sums never show on sum.
            if (cnt_q == LAST) begin
               state_d = DONE;
               sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
               cout_d  = fa_co;
`ifdef SERIAL_ADDER_SUB_EN
               ovf_d   = carry_q ^ fa_co;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN) || (state_q == DONE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
   assign ovf  = ovf_q;
`endif

endmodule
